// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions: LP line codes, LP receiver state encoding and the
// default timing constants used by both the LP transmitter and receiver.
package dphy_pkg;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  typedef enum logic [2:0] {
    RX_STOP      = 3'd0,
    RX_HS_RQST   = 3'd1,
    RX_HS_PRPR   = 3'd2,
    RX_HS_SETTLE = 3'd3,
    RX_HS_ACTIVE = 3'd4,
    RX_ERR       = 3'd5,
    RX_ESC_RQST  = 3'd6
  } rx_state_e;

  localparam int unsigned DPHY_FILTER_CYCLES = 2;
  localparam int unsigned DPHY_LPX_MIN       = 6;
  localparam int unsigned DPHY_TERM_DELAY    = 4;
  localparam int unsigned DPHY_HS_SETTLE     = 8;
  localparam int unsigned DPHY_CNT_W         = 5;

  // Case matching keeps X/Z samples out of every code.
  function automatic logic is_lp_code(input logic [1:0] v);
    logic hit;
    hit = 1'b0;
    case (v)
      LP11, LP10, LP01, LP00: hit = 1'b1;
      default:                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/dphy_lprx_seq_detect_lp_line_filter.sv
// Two-flop synchroniser on {Dp,Dn} followed by a glitch filter that accepts a
// new line state only after FILTER_CYCLES consecutive identical samples.
module lp_line_filter
  import dphy_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = DPHY_FILTER_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp,
  input  logic       dn,
  output logic [1:0] line_state
);

  localparam logic [2:0] FC = 3'(FILTER_CYCLES);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] cand;
  logic [2:0] run;
  logic [2:0] run_nxt;

  always_comb begin
    run_nxt = 3'd1;
    if (sync2 == cand) run_nxt = run + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= LP11;
      sync2      <= LP11;
      cand       <= LP11;
      run        <= 3'd0;
      line_state <= LP11;
    end else begin
      sync1 <= {dp, dn};
      sync2 <= sync1;
      // Any sample equal to the accepted state (or not a code) breaks the run.
      if (is_lp_code(sync2) && (sync2 != line_state)) begin
        cand <= sync2;
        if (run_nxt >= FC) begin
          line_state <= sync2;
          run        <= 3'd0;
        end else begin
          run <= run_nxt;
        end
      end else begin
        run <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/dphy_lprx_seq_detect.sv
// D-PHY LP receiver sequence detector: tracks LP-11 -> LP-01 -> LP-00 HS entry,
// enables termination and RxActiveHS. Optional escape detect: LPRX_ESC_DETECT_EN.
module dphy_lprx_seq_detect
  import dphy_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = DPHY_FILTER_CYCLES,
  parameter int unsigned LPX_MIN       = DPHY_LPX_MIN,
  parameter int unsigned TERM_DELAY    = DPHY_TERM_DELAY,
  parameter int unsigned HS_SETTLE     = DPHY_HS_SETTLE,
  parameter int unsigned CNT_W         = DPHY_CNT_W
) (
  input  logic       LPRX_CLK,
  input  logic       RxRst_n,
  input  logic       LPRX_EN,
  input  logic       LP_Dp,
  input  logic       LP_Dn,
  output logic       HSRX_EN,
  output logic       RxActiveHS,
  output logic       RxStopState,
  output logic       ErrControl,
  output logic [1:0] LineState,
`ifdef LPRX_ESC_DETECT_EN
  output logic       RxEscEntry,
`endif
  output rx_state_e  rx_state_dbg
);

  localparam logic [CNT_W-1:0] LPX_MIN_C   = CNT_W'(LPX_MIN);
  localparam logic [CNT_W-1:0] TERM_LAST   = CNT_W'(TERM_DELAY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(HS_SETTLE - 1);

  rx_state_e        state;
  rx_state_e        next_state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_run;

  lp_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk       (LPRX_CLK),
    .rst_n     (RxRst_n),
    .dp        (LP_Dp),
    .dn        (LP_Dn),
    .line_state(LineState)
  );

`ifdef LPRX_ESC_DETECT_EN
  logic esc_hit;
  logic esc_done;
`endif

  always_comb begin
    next_state = state;
`ifdef LPRX_ESC_DETECT_EN
    esc_hit = 1'b0;
`endif
    if (!LPRX_EN) begin
      next_state = RX_STOP;
    end else begin
      case (state)
        RX_STOP: begin
          if (LineState == LP01) next_state = RX_HS_RQST;
          else if (LineState == LP00) next_state = RX_ERR;
`ifdef LPRX_ESC_DETECT_EN
          else if (LineState == LP10) next_state = RX_ESC_RQST;
`else
          else if (LineState == LP10) next_state = RX_ERR;
`endif
        end
        RX_HS_RQST: begin
          if (LineState == LP11) next_state = RX_STOP;
          else if (LineState == LP10) next_state = RX_ERR;
          else if (LineState == LP00) next_state = (cnt >= LPX_MIN_C) ? RX_HS_PRPR : RX_ERR;
        end
        RX_HS_PRPR: begin
          if (LineState == LP11) next_state = RX_STOP;
          else if ((LineState == LP01) || (LineState == LP10)) next_state = RX_ERR;
          else if (cnt >= TERM_LAST) next_state = RX_HS_SETTLE;
        end
        // HS swing reads as LP-00, so only LP-11 is meaningful from here on.
        RX_HS_SETTLE: begin
          if (LineState == LP11) next_state = RX_STOP;
          else if (cnt >= SETTLE_LAST) next_state = RX_HS_ACTIVE;
        end
        RX_HS_ACTIVE, RX_ERR: begin
          if (LineState == LP11) next_state = RX_STOP;
        end
`ifdef LPRX_ESC_DETECT_EN
        RX_ESC_RQST: begin
          if (LineState == LP11) next_state = RX_STOP;
          else if (!esc_done) begin
            if (LineState == LP01) next_state = RX_ERR;
            else if (LineState == LP00) begin
              if (cnt >= LPX_MIN_C) esc_hit = 1'b1;
              else next_state = RX_ERR;
            end
          end
        end
`endif
        default: next_state = RX_STOP;
      endcase
    end
  end

  always_comb begin
    cnt_run = 1'b0;
    case (state)
      RX_HS_RQST, RX_HS_PRPR, RX_HS_SETTLE, RX_ESC_RQST: cnt_run = 1'b1;
      default:                                           cnt_run = 1'b0;
    endcase
  end

  always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
    if (!RxRst_n) begin
      state       <= RX_STOP;
      cnt         <= '0;
      HSRX_EN     <= 1'b0;
      RxActiveHS  <= 1'b0;
      RxStopState <= 1'b0;
      ErrControl  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (cnt_run && (cnt != '1)) cnt <= cnt + 1'b1;
      // Outputs are decoded from the next state so they line up with it.
      HSRX_EN     <= (next_state == RX_HS_SETTLE) || (next_state == RX_HS_ACTIVE);
      RxActiveHS  <= (next_state == RX_HS_ACTIVE);
      RxStopState <= (next_state == RX_STOP) && (LineState == LP11) && LPRX_EN;
      ErrControl  <= (next_state == RX_ERR) && (state != RX_ERR);
    end
  end

`ifdef LPRX_ESC_DETECT_EN
  always_ff @(posedge LPRX_CLK or negedge RxRst_n) begin
    if (!RxRst_n) begin
      esc_done   <= 1'b0;
      RxEscEntry <= 1'b0;
    end else begin
      if (next_state != state) esc_done <= 1'b0;
      else if (esc_hit) esc_done <= 1'b1;
      RxEscEntry <= esc_hit;
    end
  end
`endif

  assign rx_state_dbg = state;

endmodule
